// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised oversampling UART receiver with majority voting and frame status
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic                 clock_enable,
  input  logic                 ready_clear,
  output logic                 ready,
  output logic [DATA_BITS-1:0] received_data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] VOTE_AT     = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP   = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [2:0]             hist_q, hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   fperr_q, fperr_d;
  logic                   fferr_q, fferr_d;
  logic                   ready_q, ready_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic line;
  logic vote;
  logic at_vote;
  logic at_end;
  logic complete;

  assign line    = sync_q[1];
  // Vote over samples M-1, M (history) and M+1 (the sample taken on this tick).
  assign vote    = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
  assign at_vote = (cnt_q == VOTE_AT);
  assign at_end  = (cnt_q == LAST_SAMPLE);

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    fperr_d  = fperr_q;
    fferr_d  = fferr_q;
    complete = 1'b0;

    if (clock_enable) begin
      hist_d = {hist_q[1:0], line};
      cnt_d  = cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!line) begin
            state_d = S_START;
            cnt_d   = CW'(1);
            bit_d   = '0;
            stop_d  = 1'b0;
            fperr_d = 1'b0;
            fferr_d = 1'b0;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (at_end) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (at_vote) begin
            shift_d[bit_q] = vote;
          end
          if (at_end) begin
            cnt_d = '0;
            if (bit_q == LAST_BIT) begin
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_vote) begin
            fperr_d = (PARITY == 1) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
          end
          if (at_end) begin
            state_d = S_STOP;
            cnt_d   = '0;
          end
        end
        S_STOP: begin
          if (at_vote) begin
            fferr_d = fferr_q | ~vote;
            // Leave at mid-bit so a start edge in the back half of the stop bit is caught.
            if (stop_q == LAST_STOP) begin
              complete = 1'b1;
              state_d  = S_IDLE;
              cnt_d    = '0;
            end
          end else if (at_end) begin
            cnt_d  = '0;
            stop_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ready_d = ready_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (complete) begin
      ready_d = 1'b1;
      data_d  = shift_q;
      perr_d  = fperr_q;
      ferr_d  = fferr_q | ~vote;
      ovr_d   = ready_q & ~ready_clear;
    end else if (ready_clear) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      fperr_q <= 1'b0;
      fferr_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], serial_in};
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      fperr_q <= fperr_d;
      fferr_q <= fferr_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ready         = ready_q;
  assign received_data = data_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - frame-level model bench for three receiver configurations
module tb_uart_rx_core;
  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ce    = 1'b0;
  logic       rst_ab = 1'b1;
  logic       rst_c  = 1'b1;
  logic [2:0] ser = 3'b111;
  logic [2:0] rc  = 3'b000;
  logic [2:0] rdy, perr, ferr, ovr;
  logic [7:0] rd0, rd1;
  logic [6:0] rd2;

  // Unit 0: 8N1, unit 1: 8 bits even parity, unit 2: 7 bits odd parity two stops.
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_ab), .serial_in(ser[0]), .clock_enable(ce), .ready_clear(rc[0]),
    .ready(rdy[0]), .received_data(rd0), .parity_error(perr[0]), .framing_error(ferr[0]),
    .overrun(ovr[0]));
  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_ab), .serial_in(ser[1]), .clock_enable(ce), .ready_clear(rc[1]),
    .ready(rdy[1]), .received_data(rd1), .parity_error(perr[1]), .framing_error(ferr[1]),
    .overrun(ovr[1]));
  uart_rx_core #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_c), .serial_in(ser[2]), .clock_enable(ce), .ready_clear(rc[2]),
    .ready(rdy[2]), .received_data(rd2), .parity_error(perr[2]), .framing_error(ferr[2]),
    .overrun(ovr[2]));

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0] e_rdy = '0, e_perr = '0, e_ferr = '0, e_ovr = '0;
  logic [2:0] pend_perr = '0, pend_ferr = '0, cpl_now = '0;
  logic [8:0] e_data [3] = '{default: '0};
  logic [8:0] pend_data [3] = '{default: '0};

  function automatic int cfg_d(int u); return (u == 2) ? 7 : 8; endfunction
  function automatic int cfg_p(int u); return (u == 0) ? 0 : ((u == 1) ? 2 : 1); endfunction
  function automatic int cfg_s(int u); return (u == 2) ? 2 : 1; endfunction

  function automatic logic [8:0] act_data(int u);
    case (u)
      0:       return {1'b0, rd0};
      1:       return {1'b0, rd1};
      default: return {2'b0, rd2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: a completion is due at the tick edge the driver flags.
  always @(posedge clk or negedge rst_ab or negedge rst_c) begin
    for (int u = 0; u < 3; u++) begin
      if ((u == 2) ? !rst_c : !rst_ab) begin
        e_rdy[u] = 1'b0; e_perr[u] = 1'b0; e_ferr[u] = 1'b0; e_ovr[u] = 1'b0; e_data[u] = '0;
      end else if (cpl_now[u] && ce) begin
        e_ovr[u]  = e_rdy[u] & ~rc[u];
        e_rdy[u]  = 1'b1;
        e_data[u] = pend_data[u];
        e_perr[u] = pend_perr[u];
        e_ferr[u] = pend_ferr[u];
      end else if (rc[u]) begin
        e_rdy[u] = 1'b0;
        e_ovr[u] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d ready", u), {8'b0, rdy[u]}, {8'b0, e_rdy[u]});
      chk($sformatf("u%0d data", u), act_data(u), e_data[u]);
      chk($sformatf("u%0d parity_error", u), {8'b0, perr[u]}, {8'b0, e_perr[u]});
      chk($sformatf("u%0d framing_error", u), {8'b0, ferr[u]}, {8'b0, e_ferr[u]});
      chk($sformatf("u%0d overrun", u), {8'b0, ovr[u]}, {8'b0, e_ovr[u]});
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (ce !== 1'b1) @(posedge clk);
  endtask

  function automatic logic lev(int u, logic [8:0] data, logic pbit, logic stopv, int j);
    int b;
    b = j / OS;
    if (b == 0) return 1'b0;
    if (b <= cfg_d(u)) return data[b-1];
    if (cfg_p(u) != 0 && b == cfg_d(u) + 1) return pbit;
    if (b <= cfg_d(u) + ((cfg_p(u) != 0) ? 1 : 0) + cfg_s(u)) return stopv;
    return 1'b1;
  endfunction

  // Sample j of the frame is set just after one tick and taken by the DUT on the next.
  task automatic send(input int u, input logic [8:0] data, input bit bad_par, input logic stopv,
                      input int glitch_at, input int abort_at, input bit clr_at_done);
    int d, p, s, c, total;
    logic [8:0] dm;
    logic good, pbit;
    d = cfg_d(u);
    p = (cfg_p(u) != 0) ? 1 : 0;
    s = cfg_s(u);
    c = (d + p + s) * OS + M + 1;
    total = (1 + d + p + s) * OS + 2 * OS;
    dm = data & 9'((1 << d) - 1);
    good = (cfg_p(u) == 2) ? ^dm : ~^dm;
    pbit = bad_par ? ~good : good;
    for (int j = 0; j < total; j++) begin
      wait_tick();
      #2;
      if (j == abort_at) begin
        rst_c  = 1'b0;
        ser[u] = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_c = 1'b1;
        return;
      end
      ser[u] = lev(u, dm, pbit, stopv, j) ^ (j == glitch_at);
      if (j == c) begin
        pend_data[u] = dm;
        pend_perr[u] = (p != 0) && bad_par;
        pend_ferr[u] = ~stopv;
        cpl_now[u]   = 1'b1;
        if (clr_at_done) begin
          wait (ce === 1'b1);
          rc[u] = 1'b1;
        end
      end
      if (j == c + 1) begin
        cpl_now[u] = 1'b0;
        rc[u]      = 1'b0;
      end
    end
  endtask

  task automatic clr(input int u);
    @(posedge clk);
    #2 rc[u] = 1'b1;
    @(posedge clk);
    #2 rc[u] = 1'b0;
  endtask

  task automatic false_start(input int u, input int n);
    for (int j = 0; j < n; j++) begin
      wait_tick();
      #2 ser[u] = 1'b0;
    end
    wait_tick();
    #2 ser[u] = 1'b1;
    repeat (3 * OS) wait_tick();
  endtask

  initial begin
    #2 rst_ab = 1'b0; rst_c = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_ab = 1'b1; rst_c = 1'b1;
    chk("reset ready", {6'b0, rdy}, 9'h000);
    chk("reset data", act_data(0), 9'h000);
    repeat (4) wait_tick();

    send(0, 9'hA5, 0, 1'b1, -1, -1, 0);
    chk("A5 data", act_data(0), 9'h0A5);
    chk("A5 ready", {8'b0, rdy[0]}, 9'h001);
    clr(0);
    chk("clear keeps data", act_data(0), 9'h0A5);
    send(0, 9'h3C, 0, 1'b1, -1, -1, 0);
    chk("3C data", act_data(0), 9'h03C);
    chk("3C flags", {6'b0, perr[0], ferr[0], ovr[0]}, 9'h000);
    clr(0);

    send(1, 9'h07, 1, 1'b1, -1, -1, 0);
    chk("07 data", act_data(1), 9'h007);
    chk("07 parity_error", {8'b0, perr[1]}, 9'h001);
    clr(1);
    send(1, 9'h03, 0, 1'b1, -1, -1, 0);
    chk("03 parity_error", {8'b0, perr[1]}, 9'h000);
    clr(1);

    send(0, 9'h55, 0, 1'b0, -1, -1, 0);
    chk("55 data", act_data(0), 9'h055);
    chk("55 framing_error", {8'b0, ferr[0]}, 9'h001);
    chk("55 ready", {8'b0, rdy[0]}, 9'h001);
    clr(0);
    send(0, 9'h0F, 0, 1'b1, -1, -1, 0);
    chk("0F framing_error", {8'b0, ferr[0]}, 9'h000);
    clr(0);

    false_start(0, 3);
    chk("false start ready", {8'b0, rdy[0]}, 9'h000);
    chk("false start data", act_data(0), 9'h00F);
    send(0, 9'hFF, 0, 1'b1, 3 * OS + M, -1, 0);
    chk("glitch data", act_data(0), 9'h0FF);
    clr(0);

    send(0, 9'h11, 0, 1'b1, -1, -1, 0);
    send(0, 9'h22, 0, 1'b1, -1, -1, 0);
    chk("overrun data", act_data(0), 9'h022);
    chk("overrun set", {8'b0, ovr[0]}, 9'h001);
    clr(0);
    chk("overrun cleared", {7'b0, rdy[0], ovr[0]}, 9'h000);
    send(0, 9'h44, 0, 1'b1, -1, -1, 0);
    send(0, 9'h66, 0, 1'b1, -1, -1, 1);
    chk("clear on completion", {7'b0, rdy[0], ovr[0]}, 9'h002);
    chk("clear on completion data", act_data(0), 9'h066);
    clr(0);

    send(2, 9'h5A, 0, 1'b1, -1, -1, 0);
    chk("5A data", act_data(2), 9'h05A);
    chk("5A flags", {7'b0, perr[2], ferr[2]}, 9'h000);
    clr(2);
    send(2, 9'h2B, 0, 1'b1, -1, 4 * OS + 4, 0);
    repeat (3 * OS) wait_tick();
    chk("abort ready", {8'b0, rdy[2]}, 9'h000);
    chk("abort data", act_data(2), 9'h000);
    send(2, 9'h33, 0, 1'b1, -1, -1, 0);
    chk("33 data", act_data(2), 9'h033);
    chk("33 ready", {8'b0, rdy[2]}, 9'h001);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
